button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Conditions the raw push-button inputs before they drive the Nios button PIO input (nios_buttons_external_connection_export[2:0]).
- Synchronises each button into the clk_clk domain.
- Debounces each button with a per-button stability counter.
- Produces single-cycle press/release pulses.
- Keeps sticky per-button press flags that software or fabric logic can clear.
The block sits between the board KEY pins and the soc_system instance in the top level.

Parameters:
NUM_BUTTONS, 3, number of buttons; matches the PIO width.
DEBOUNCE_CYCLES, 500000, cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); legal range >= 1.
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
clk_clk  input  1  system clock, the same clock that drives soc_system.
reset_reset_n  input  1  synchronous, active-low reset.
buttons_raw_n  input  NUM_BUTTONS  raw KEY pins; active-low (0 = pressed); asynchronous to clk_clk.
buttons_db_n  output  NUM_BUTTONS  debounced level, active-low; connects to nios_buttons_external_connection_export.
press_pulse  output  NUM_BUTTONS  one-cycle high when the debounced level goes 1->0.
release_pulse  output  NUM_BUTTONS  one-cycle high when the debounced level goes 0->1.
press_flag  output  NUM_BUTTONS  sticky flag, set by press_pulse.
flag_clr  input  NUM_BUTTONS  per-bit synchronous clear of press_flag.

Behaviour:
- One clock domain. Reset is synchronous and active-low: all state updates on the rising edge of clk_clk while reset_reset_n = 0.
- Reset values:
  - sync stages = all 1s
  - buttons_db_n = all 1s (released)
  - counters = 0
  - press_pulse = 0, release_pulse = 0, press_flag = 0
- Synchroniser, per bit: two flops. s1 <= buttons_raw_n; s2 <= s1. No other logic reads s1.
- Debounce, per button i, every cycle:
  - If s2[i] == buttons_db_n[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: buttons_db_n[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Glitch rejection: any cycle in which s2 matches the stable level resets the count, so a bounce restarts the full window.
- Latency: a raw level change captured at edge E reaches s2 at E+1. buttons_db_n changes at edge E+1+DEBOUNCE_CYCLES, provided the level holds throughout.
  - DEBOUNCE_CYCLES=1 gives buttons_db_n two cycles after the raw capture edge.
- Pulses are registered and asserted on the same edge that buttons_db_n updates, for exactly one cycle.
  - press_pulse[i] on a 1->0 transition.
  - release_pulse[i] on a 0->1 transition.
  - press_pulse and release_pulse are never high together for the same bit.
- press_flag[i] update:
  - Set on the edge after press_pulse[i]=1 (i.e. flag = registered OR of pulse).
  - Cleared on the edge where flag_clr[i]=1.
  - If set and clear occur in the same cycle, set wins and the flag stays 1.
  - flag_clr while the flag is already 0 has no effect.
- Buttons are fully independent. Simultaneous presses on several bits produce simultaneous pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around path.
- Reset asserted mid-count: counter, level, pulses and flags return to reset values at that edge. After reset is released, a button that is still held pressed needs 2+DEBOUNCE_CYCLES cycles to be accepted and then produces a press_pulse.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8, NUM_BUTTONS=3.)
1. Reset: hold reset_reset_n=0 for 3 cycles with buttons_raw_n=3'b010 -> buttons_db_n=3'b111, pulses=0, press_flag=0 throughout reset.
2. Clean press: drive bit0 to 0 and hold it -> buttons_db_n[0] falls exactly 9 cycles after the capture edge. press_pulse[0] is high for 1 cycle on that edge. press_flag[0]=1 on the next edge.
3. Bounce: bit1 goes low for 5 cycles, high for 1 cycle, then low for 20 cycles -> no change during the first burst; buttons_db_n[1] falls 9 cycles after the final low capture; exactly one press_pulse.
4. Release and flag clear: release bit0 -> release_pulse[0] after 9 cycles. Pulse flag_clr[0] -> press_flag[0]=0 on the next edge.
5. Set/clear collision: assert flag_clr[2] in the same cycle as press_pulse[2] -> press_flag[2] stays 1.
6. Reset mid-count: bit0 low; assert reset at count 5; release reset with bit0 still low -> no pulse during reset; press_pulse[0] fires 10 cycles after reset release.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions the raw active-low push-button pins before they reach the button
// PIO: two-flop synchroniser, per-button debounce counter, one-cycle
// press/release pulses and a sticky press flag per button.
//
// Ports
//   clk_clk        system clock (same clock as soc_system)
//   reset_reset_n  synchronous active-low reset
//   buttons_raw_n  raw KEY pins, active-low, asynchronous to clk_clk
//   buttons_db_n   debounced level, active-low, to the button PIO
//   press_pulse    one-cycle pulse on a debounced 1->0 transition
//   release_pulse  one-cycle pulse on a debounced 0->1 transition
//   press_flag     sticky flag set by press_pulse
//   flag_clr       per-bit clear of press_flag (a simultaneous set wins)
module button_conditioner #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw_n,
  output logic [NUM_BUTTONS-1:0] buttons_db_n,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] press_flag,
  input  logic [NUM_BUTTONS-1:0] flag_clr
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] s1;
  logic [NUM_BUTTONS-1:0] s2;
  logic [CNT_W-1:0]       cnt [NUM_BUTTONS];

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1            <= '1;
      s2            <= '1;
      buttons_db_n  <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
      press_flag    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1            <= buttons_raw_n;
      s2            <= s1;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        // Any sample that agrees with the accepted level restarts the window,
        // so a single bounce costs a full debounce period.
        if (s2[i] == buttons_db_n[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          buttons_db_n[i]  <= s2[i];
          cnt[i]           <= '0;
          press_pulse[i]   <= ~s2[i];
          release_pulse[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // Set has priority over clear.
      press_flag <= press_pulse | (press_flag & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, 3 buttons.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_button_conditioner;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [2:0] buttons_raw_n;
  logic [2:0] buttons_db_n;
  logic [2:0] press_pulse;
  logic [2:0] release_pulse;
  logic [2:0] press_flag;
  logic [2:0] flag_clr;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_BUTTONS    (3),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .buttons_raw_n(buttons_raw_n),
    .buttons_db_n (buttons_db_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_flag   (press_flag),
    .flag_clr     (flag_clr)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] db, input logic [2:0] pp,
                         input logic [2:0] rp, input logic [2:0] fl);
    chk({tag, ".db"}, buttons_db_n, db);
    chk({tag, ".press"}, press_pulse, pp);
    chk({tag, ".release"}, release_pulse, rp);
    chk({tag, ".flag"}, press_flag, fl);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    buttons_raw_n = 3'b010;
    flag_clr      = 3'b000;

    // 1. reset held for 3 cycles with a button pattern on the pins
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all("reset", 3'b111, 3'b000, 3'b000, 3'b000);
    end
    buttons_raw_n = 3'b111;
    reset_reset_n = 1'b1;
    step(3);
    chk_all("idle", 3'b111, 3'b000, 3'b000, 3'b000);

    // 2. clean press on bit0: captured at the next edge, accepted 9 edges later
    buttons_raw_n = 3'b110;
    step(1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk_all("press0_wait", 3'b111, 3'b000, 3'b000, 3'b000);
    end
    step(1);
    chk_all("press0_edge", 3'b110, 3'b001, 3'b000, 3'b000);
    step(1);
    chk_all("press0_flag", 3'b110, 3'b000, 3'b000, 3'b001);

    // 3. bounce on bit1: 5 low, 1 high, then 20 low
    buttons_raw_n = 3'b100;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bounce_burst.db", buttons_db_n, 3'b110);
    end
    buttons_raw_n = 3'b110;
    step(1);
    buttons_raw_n = 3'b100;
    step(1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("bounce_wait.db", buttons_db_n, 3'b110);
      chk("bounce_wait.press", press_pulse, 3'b000);
    end
    step(1);
    chk_all("bounce_edge", 3'b100, 3'b010, 3'b000, 3'b001);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bounce_after.press", press_pulse, 3'b000);
    end
    chk_all("bounce_flag", 3'b100, 3'b000, 3'b000, 3'b011);

    // 4. release bit0, then clear its flag
    buttons_raw_n = 3'b101;
    step(1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("release0_wait.db", buttons_db_n, 3'b100);
      chk("release0_wait.release", release_pulse, 3'b000);
    end
    step(1);
    chk_all("release0_edge", 3'b101, 3'b000, 3'b001, 3'b011);
    step(1);
    chk_all("release0_after", 3'b101, 3'b000, 3'b000, 3'b011);
    flag_clr = 3'b001;
    step(1);
    flag_clr = 3'b000;
    chk("clr0.flag", press_flag, 3'b010);
    flag_clr = 3'b001;
    step(1);
    flag_clr = 3'b000;
    chk("clr0_again.flag", press_flag, 3'b010);

    // 5. press bit2 with its clear landing on the same edge as the flag set
    buttons_raw_n = 3'b001;
    step(1);
    step(8);
    chk("press2_wait.press", press_pulse, 3'b000);
    step(1);
    chk_all("press2_edge", 3'b001, 3'b100, 3'b000, 3'b010);
    flag_clr = 3'b100;
    step(1);
    flag_clr = 3'b000;
    chk("collision.flag", press_flag, 3'b110);
    flag_clr = 3'b100;
    step(1);
    flag_clr = 3'b000;
    chk("clr2.flag", press_flag, 3'b010);

    // release everything and clear all flags
    buttons_raw_n = 3'b111;
    step(12);
    flag_clr = 3'b111;
    step(1);
    flag_clr = 3'b000;
    chk_all("all_released", 3'b111, 3'b000, 3'b000, 3'b000);

    // 6. reset while bit0 is mid-count, button still held afterwards
    buttons_raw_n = 3'b110;
    step(1);
    step(6);
    reset_reset_n = 1'b0;
    step(1);
    chk_all("midreset_a", 3'b111, 3'b000, 3'b000, 3'b000);
    step(1);
    chk_all("midreset_b", 3'b111, 3'b000, 3'b000, 3'b000);
    reset_reset_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("postreset_wait.db", buttons_db_n, 3'b111);
      chk("postreset_wait.press", press_pulse, 3'b000);
    end
    step(1);
    chk_all("postreset_edge", 3'b110, 3'b001, 3'b000, 3'b000);

    // simultaneous press of bits 1 and 2
    buttons_raw_n = 3'b000;
    step(1);
    step(8);
    chk("simul_wait.db", buttons_db_n, 3'b110);
    step(1);
    chk_all("simul_edge", 3'b000, 3'b110, 3'b000, 3'b001);
    step(1);
    chk_all("simul_flag", 3'b000, 3'b000, 3'b000, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
